sqrt_inverse_squarer: RTL

Sequential fixed-point squarer: the inverse of the iterative square-root unit. It rebuilds the radicand from a (root, remainder) pair as rad = (root² + rem) >> FRACTION_WIDTH. It shares the root unit's start/busy/valid handshake and fixed-point format, so the math library uses it to regenerate radicands and to round-trip-check square-root results.

---
 rtl/sqrt_inverse_squarer.sv | 111 +++++++++++
 1 files changed

// File: rtl/sqrt_inverse_squarer.sv
// Sequential fixed-point squarer: rebuilds rad = (root^2 + rem) >> FRACTION_WIDTH
// with a one-bit-per-cycle shift-add multiplier behind a start/busy/valid handshake.
module sqrt_inverse_squarer #(
  parameter int unsigned TOTAL_WIDTH    = 8,
  parameter int unsigned FRACTION_WIDTH = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [TOTAL_WIDTH-1:0] root,
  input  logic [TOTAL_WIDTH-1:0] rem,
  output logic                   busy,
  output logic                   valid,
  output logic [TOTAL_WIDTH-1:0] rad,
  output logic                   ovf
);

  localparam int unsigned W  = TOTAL_WIDTH;
  localparam int unsigned MW = 2 * TOTAL_WIDTH;
  localparam int unsigned AW = 2 * TOTAL_WIDTH + 1;
  localparam int unsigned IW = (TOTAL_WIDTH == 2) ? 1 : $clog2(TOTAL_WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_n;
  logic [MW-1:0]  mc, mc_n;
  logic [W-1:0]   mp, mp_n;
  logic [AW-1:0]  acc, acc_n;
  logic [W-1:0]   r, r_n;
  logic [IW-1:0]  i, i_n;
  logic           busy_n, valid_n, ovf_n;
  logic [W-1:0]   rad_n;

  logic [AW-1:0]  acc_step_c;
  logic [AW-1:0]  sum_c;

  // Partial product for this iteration, then the remainder add and fractional truncation.
  assign acc_step_c = acc + (mp[0] ? AW'(mc) : '0);
  assign sum_c      = (acc_step_c + AW'(r)) >> FRACTION_WIDTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mc    <= '0;
      mp    <= '0;
      acc   <= '0;
      r     <= '0;
      i     <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      rad   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      mc    <= mc_n;
      mp    <= mp_n;
      acc   <= acc_n;
      r     <= r_n;
      i     <= i_n;
      busy  <= busy_n;
      valid <= valid_n;
      rad   <= rad_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    mc_n    = mc;
    mp_n    = mp;
    acc_n   = acc;
    r_n     = r;
    i_n     = i;
    busy_n  = busy;
    valid_n = valid;
    rad_n   = rad;
    ovf_n   = ovf;

    case (state)
      IDLE: ;
      RUN: begin
        mc_n = mc << 1;
        mp_n = mp >> 1;
        if (i == IW'(W - 1)) begin
          rad_n   = sum_c[W-1:0];
          ovf_n   = |sum_c[AW-1:W];
          busy_n  = 1'b0;
          valid_n = 1'b1;
          state_n = IDLE;
        end else begin
          i_n   = i + IW'(1);
          acc_n = acc_step_c;
        end
      end
      default: state_n = IDLE;
    endcase

    // A start edge overrides any iteration or completion in the same cycle.
    if (start) begin
      mc_n    = MW'(root);
      mp_n    = root;
      r_n     = rem;
      acc_n   = '0;
      i_n     = '0;
      busy_n  = 1'b1;
      valid_n = 1'b0;
      state_n = RUN;
    end
  end

endmodule
